// File: rtl/modmul_barrett_pipe.sv
// modmul_barrett_pipe: (a*w) mod 3329 over a 4-stage Barrett pipeline
// with valid/ready flow control and a tag carried in lockstep.
module modmul_barrett_pipe #(
   parameter int Q     = 3329,
   parameter int M     = 5039,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      a,
   input  logic [15:0]      w,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      p,
   output logic [TAG_W-1:0] tag_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             range_err
);
   logic             en, v1, v2, v3;
   logic [TAG_W-1:0] t1, t2, t3;
   logic [23:0]      x1, x2;
   logic [11:0]      qe2;
   logic [12:0]      r3;
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {v1, v2, v3, out_valid, range_err} <= '0;
         {t1, t2, t3, tag_out} <= '0;
         {x1, x2, qe2, r3, p} <= '0;
      end else begin
         if (in_valid && en && (a >= 16'(Q) || w >= 16'(Q)))
            range_err <= 1'b1;
         if (en) begin
            v1        <= in_valid;
            t1        <= tag_in;
            x1        <= 24'(32'(a) * 32'(w));
            v2        <= v1;
            t2        <= t1;
            x2        <= x1;
            qe2       <= 12'((48'(x1) * 48'(M)) >> 24);
            v3        <= v2;
            t3        <= t2;
            // estimate is low by at most one, so r lands in [0, 2Q)
            r3        <= 13'(x2 - 24'(qe2) * 24'(Q));
            out_valid <= v3;
            tag_out   <= t3;
            p         <= (r3 >= 13'(Q)) ? 16'(r3 - 13'(Q)) : 16'(r3);
         end
      end
   end
endmodule

// File: tb/tb_modmul_barrett_pipe.sv
// tb_modmul_barrett_pipe: directed vector table plus stream, backpressure,
// range-error and mid-stream reset sequences against a (a*w)%3329 model.
module tb_modmul_barrett_pipe;
   typedef struct {
      logic [15:0] a;
      logic [15:0] w;
      logic [7:0]  tag;
      logic [15:0] exp;
   } vec_t;
   typedef struct {
      logic [15:0] p;
      logic [7:0]  t;
   } exp_t;

   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
   logic [15:0] a = 0, w = 0;
   logic [7:0]  tag_in = 0;
   logic        in_ready, out_valid, range_err;
   logic [15:0] p;
   logic [7:0]  tag_out;

   int   n_cmp = 0, n_err = 0;
   bit   mon_en = 0;
   int   cyc = 0, ocnt = 0, first = -1, last = -1;
   exp_t sb[$];

   modmul_barrett_pipe #(.Q(3329), .M(5039), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .w(w), .tag_in(tag_in),
      .in_valid(in_valid), .in_ready(in_ready), .p(p), .tag_out(tag_out),
      .out_valid(out_valid), .out_ready(out_ready), .range_err(range_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) if (mon_en) begin
      cyc++;
      if (in_valid && in_ready)
         sb.push_back('{16'((int'(a) * int'(w)) % 3329), tag_in});
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("stream_p", p, e.p);
            chk("stream_tag", tag_out, e.t);
         end
         ocnt++;
         if (first < 0) first = cyc;
         last = cyc;
      end
   end

   task automatic run_one(input logic [15:0] ai, input logic [15:0] wi,
                          input logic [7:0] ti, input logic [15:0] ex, input bit chkp);
      int n;
      a = ai; w = wi; tag_in = ti; in_valid = 1;
      @(negedge clk) chk("in_ready", in_ready, 1);
      @(posedge clk) #1 in_valid = 0;
      n = 1;
      while (!out_valid && n < 12) begin
         @(posedge clk) #1;
         n++;
      end
      chk("latency", n, 4);
      if (chkp) chk("p", p, ex);
      chk("tag", tag_out, ti);
      @(posedge clk) #1;
   endtask

   task automatic feed(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         int k;
         @(posedge clk) #1;
         a = 16'($urandom_range(0, 3328));
         w = 16'($urandom_range(0, 3328));
         tag_in = 8'(base + i);
         in_valid = 1;
         k = 0;
         @(negedge clk);
         while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (k >= 50) chk("feed_timeout", 1, 0);
      end
      @(posedge clk) #1 in_valid = 0;
   endtask

   initial begin
      vec_t tbl[8];
      int   k;
      logic [15:0] hp;
      logic [7:0]  ht;
      tbl[0] = '{16'd17,   16'd17,   8'd1, 16'd289};
      tbl[1] = '{16'd1000, 16'd2000, 8'd2, 16'd2600};
      tbl[2] = '{16'd3328, 16'd3328, 8'd3, 16'd1};
      tbl[3] = '{16'd0,    16'd3328, 8'd4, 16'd0};
      tbl[4] = '{16'd3328, 16'd2,    8'd5, 16'd3327};
      tbl[5] = '{16'd1,    16'd3328, 8'd6, 16'd3328};
      tbl[6] = '{16'd2,    16'd3,    8'd7, 16'd6};
      tbl[7] = '{16'd3328, 16'd1,    8'd8, 16'd3328};

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_p", p, 0);
      chk("rst_tag", tag_out, 0);
      chk("rst_range_err", range_err, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk) #1 rst_n = 1;

      for (int i = 0; i < 8; i++)
         run_one(tbl[i].a, tbl[i].w, tbl[i].tag, tbl[i].exp, 1);
      chk("no_range_err", range_err, 0);

      run_one(16'd3329, 16'd5, 8'd20, 16'd0, 0);
      chk("range_err_set", range_err, 1);
      run_one(16'd2, 16'd3, 8'd21, 16'd6, 1);
      chk("range_err_held", range_err, 1);

      cyc = 0; ocnt = 0; first = -1; last = -1; mon_en = 1;
      feed(64, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("stream_count", ocnt, 64);
      chk("stream_span", last - first + 1, 64);
      chk("stream_sb_empty", sb.size(), 0);

      ocnt = 0;
      fork
         feed(10, 100);
         begin
            k = 0;
            @(negedge clk);
            while (!out_valid && k < 50) begin
               @(negedge clk);
               k++;
            end
            chk("bp_reach", out_valid, 1);
            @(posedge clk) #1 out_ready = 0;
            hp = p; ht = tag_out;
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready", in_ready, 0);
               chk("bp_out_valid", out_valid, 1);
               chk("bp_p_hold", p, hp);
               chk("bp_tag_hold", tag_out, ht);
            end
            @(posedge clk) #1 out_ready = 1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("bp_count", ocnt, 10);
      chk("bp_sb_empty", sb.size(), 0);
      mon_en = 0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk) #1;
         a = 16'(100 + i); w = 16'(7); tag_in = 8'(200 + i); in_valid = 1;
      end
      @(posedge clk) #1 in_valid = 0; rst_n = 0;
      #1;
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_p", p, 0);
      chk("mrst_range_err", range_err, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      k = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) k++;
      end
      chk("mrst_no_stale", k, 0);
      @(posedge clk) #1;
      run_one(16'd17, 16'd17, 8'd9, 16'd289, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
